// File: rtl/mem_stage.sv
// Pipeline MEM stage: data memory with a configurable wait-state stall FSM and MEM/WB latch.
// Optional macro MEM_MISALIGN_CHK_EN turns misaligned accesses into single-cycle, write-suppressed no-ops.
module mem_stage #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_valid,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        EX_MEM_memtoreg,
    input  logic        EX_MEM_regwrite,
    input  logic [31:0] EX_MEM_alu_result,
    input  logic [31:0] EX_MEM_write_data,
    input  logic [4:0]  EX_MEM_write_reg,
    output logic        MEM_WB_valid,
    output logic        MEM_WB_memtoreg,
    output logic        MEM_WB_regwrite,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  MEM_WB_write_reg,
    output logic        mem_stall
);

    localparam logic [3:0] WS_CNT   = 4'(WAIT_STATES);
    localparam logic       HAS_WAIT = (WAIT_STATES > 0);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic               valid_q;
    logic               memtoreg_q;
    logic               regwrite_q;
    logic [31:0]        rdata_q;
    logic [31:0]        alu_q;
    logic [4:0]         wreg_q;
    logic [31:0]        rdata_d;

    logic [31:0]        mem_q [0:(1 << ADDR_W) - 1] = '{default: '0};

    logic [ADDR_W-1:0]  waddr;
    logic               misalign;
    logic               access;
    logic               complete;
    logic               store_en;
    logic               unused_addr_bits;

    assign waddr            = EX_MEM_alu_result[ADDR_W+1:2];
    assign unused_addr_bits = ^{EX_MEM_alu_result[31:ADDR_W+2], EX_MEM_alu_result[1:0]};

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign = (EX_MEM_alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Misaligned accesses (when checked) behave like non-memory ops: no stall, no write.
    assign access = EX_MEM_valid & (EX_MEM_memread | EX_MEM_memwrite) & ~misalign;

    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE:  mem_stall = access & HAS_WAIT;
            S_WAIT:  mem_stall = (cnt_q != 4'd1);
            default: mem_stall = 1'b0;
        endcase
    end

    assign complete = EX_MEM_valid & ~mem_stall;
    assign store_en = complete & access & EX_MEM_memwrite & ~rst;

    // Store wins when both memread and memwrite are set, so a load needs memwrite low.
    always_comb begin
        rdata_d = '0;
        if (access && EX_MEM_memread && !EX_MEM_memwrite)
            rdata_d = mem_q[waddr];
    end

    always_ff @(posedge clk) begin
        if (store_en)
            mem_q[waddr] <= EX_MEM_write_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            rdata_q    <= '0;
            alu_q      <= '0;
            wreg_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access && HAS_WAIT) begin
                        state_q <= S_WAIT;
                        cnt_q   <= WS_CNT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (complete) begin
                valid_q    <= 1'b1;
                memtoreg_q <= EX_MEM_memtoreg;
                regwrite_q <= EX_MEM_regwrite & ~misalign;
                rdata_q    <= rdata_d;
                alu_q      <= EX_MEM_alu_result;
                wreg_q     <= EX_MEM_write_reg;
            end else begin
                valid_q    <= 1'b0;
                memtoreg_q <= 1'b0;
                regwrite_q <= 1'b0;
            end
        end
    end

    assign MEM_WB_valid     = valid_q;
    assign MEM_WB_memtoreg  = memtoreg_q;
    assign MEM_WB_regwrite  = regwrite_q;
    assign read_data        = rdata_q;
    assign mem_alu_result   = alu_q;
    assign MEM_WB_write_reg = wreg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus scoreboard on a WAIT_STATES=2 instance,
// hand sequences for reset-during-wait and a WAIT_STATES=0 instance.
module tb_mem_stage;

    logic        clk;
    logic        rst;

    logic        v, rd, wr, m2r, rw;
    logic [31:0] alu, wdata;
    logic [4:0]  wreg;
    logic        o_valid, o_m2r, o_rw, stall;
    logic [31:0] o_rd, o_alu;
    logic [4:0]  o_wreg;

    logic        z_v, z_rd, z_wr, z_m2r, z_rw;
    logic [31:0] z_alu, z_wdata;
    logic [4:0]  z_wreg;
    logic        z_valid, z_om2r, z_orw, z_stall;
    logic [31:0] z_ord, z_oalu;
    logic [4:0]  z_owreg;

    mem_stage #(.ADDR_W(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_valid(v), .EX_MEM_memread(rd), .EX_MEM_memwrite(wr),
        .EX_MEM_memtoreg(m2r), .EX_MEM_regwrite(rw),
        .EX_MEM_alu_result(alu), .EX_MEM_write_data(wdata), .EX_MEM_write_reg(wreg),
        .MEM_WB_valid(o_valid), .MEM_WB_memtoreg(o_m2r), .MEM_WB_regwrite(o_rw),
        .read_data(o_rd), .mem_alu_result(o_alu), .MEM_WB_write_reg(o_wreg),
        .mem_stall(stall)
    );

    mem_stage #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .EX_MEM_valid(z_v), .EX_MEM_memread(z_rd), .EX_MEM_memwrite(z_wr),
        .EX_MEM_memtoreg(z_m2r), .EX_MEM_regwrite(z_rw),
        .EX_MEM_alu_result(z_alu), .EX_MEM_write_data(z_wdata), .EX_MEM_write_reg(z_wreg),
        .MEM_WB_valid(z_valid), .MEM_WB_memtoreg(z_om2r), .MEM_WB_regwrite(z_orw),
        .read_data(z_ord), .mem_alu_result(z_oalu), .MEM_WB_write_reg(z_owreg),
        .mem_stall(z_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, rd, wr, m2r, rw;
        logic [31:0] alu, wdata;
        logic [4:0]  wreg;
        logic [31:0] exp_rd;
        logic        exp_rw;
        int          exp_stalls;
    } vec_t;

    typedef struct {
        logic        v, m2r, rw;
        logic [31:0] alu, rd;
        logic [4:0]  wreg;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_alu = '0, last_rd = '0;
    logic [4:0]  last_wreg = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic v_, logic rd_, logic wr_, logic m2r_, logic rw_,
                                logic [31:0] alu_, logic [31:0] wd_, logic [4:0] wreg_,
                                logic [31:0] erd, logic erw, int est);
        vec_t t;
        t.v = v_; t.rd = rd_; t.wr = wr_; t.m2r = m2r_; t.rw = rw_;
        t.alu = alu_; t.wdata = wd_; t.wreg = wreg_;
        t.exp_rd = erd; t.exp_rw = erw; t.exp_stalls = est;
        return t;
    endfunction

    task automatic run_vec(input vec_t t, input int idx);
        exp_t e;
        int   stalls;
        @(negedge clk);
        v = t.v; rd = t.rd; wr = t.wr; m2r = t.m2r; rw = t.rw;
        alu = t.alu; wdata = t.wdata; wreg = t.wreg;
        e.v    = t.v;
        e.m2r  = t.v ? t.m2r : 1'b0;
        e.rw   = t.v ? t.exp_rw : 1'b0;
        e.alu  = t.v ? t.alu : last_alu;
        e.wreg = t.v ? t.wreg : last_wreg;
        e.rd   = t.v ? t.exp_rd : last_rd;
        sb.push_back(e);
        #1;
        stalls = 0;
        while (stall === 1'b1 && stalls < 20) begin
            stalls++;
            @(posedge clk); #1;
            chk($sformatf("v%0d stalled valid", idx), 32'(o_valid), 32'd0);
            chk($sformatf("v%0d stalled regwrite", idx), 32'(o_rw), 32'd0);
            chk($sformatf("v%0d stalled alu hold", idx), o_alu, last_alu);
            @(negedge clk); #1;
        end
        chk($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(t.exp_stalls));
        @(posedge clk); #1;
        e = sb.pop_front();
        chk($sformatf("v%0d valid", idx), 32'(o_valid), 32'(e.v));
        chk($sformatf("v%0d memtoreg", idx), 32'(o_m2r), 32'(e.m2r));
        chk($sformatf("v%0d regwrite", idx), 32'(o_rw), 32'(e.rw));
        chk($sformatf("v%0d alu_result", idx), o_alu, e.alu);
        chk($sformatf("v%0d write_reg", idx), 32'(o_wreg), 32'(e.wreg));
        chk($sformatf("v%0d read_data", idx), o_rd, e.rd);
        last_alu = e.alu; last_wreg = e.wreg; last_rd = e.rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 0, 2);
        vecs[1]  = mk(1, 1, 0, 1, 1, 32'h10, 32'h0, 5'd3, 32'hDEADBEEF, 1, 2);
        vecs[2]  = mk(1, 0, 0, 0, 1, 32'h5, 32'h0, 5'd7, 32'h0, 1, 0);
`ifdef MEM_MISALIGN_CHK_EN
        vecs[3]  = mk(1, 0, 1, 0, 1, 32'h13, 32'h11223344, 5'd4, 32'h0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 1, 1, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1, 2);
`else
        vecs[3]  = mk(1, 0, 1, 0, 1, 32'h13, 32'h11223344, 5'd4, 32'h0, 1, 2);
        vecs[4]  = mk(1, 1, 0, 1, 1, 32'h10, 32'h0, 5'd5, 32'h11223344, 1, 2);
`endif
        vecs[5]  = mk(1, 1, 1, 1, 1, 32'h40, 32'hA5A5A5A5, 5'd6, 32'h0, 1, 2);
        vecs[6]  = mk(1, 1, 0, 1, 1, 32'h40, 32'h0, 5'd8, 32'hA5A5A5A5, 1, 2);
        vecs[7]  = mk(1, 0, 1, 0, 0, 32'hFFFF0044, 32'h5555AAAA, 5'd0, 32'h0, 0, 2);
        vecs[8]  = mk(1, 1, 0, 1, 1, 32'h44, 32'h0, 5'd9, 32'h5555AAAA, 1, 2);
        vecs[9]  = mk(1, 1, 0, 1, 1, 32'h80, 32'h0, 5'd10, 32'h0, 1, 2);
        vecs[10] = mk(0, 1, 0, 1, 1, 32'h99, 32'h0, 5'd11, 32'h0, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 1, 32'hABC, 32'h0, 5'd12, 32'h0, 1, 0);

        rst = 1'b1;
        {v, rd, wr, m2r, rw} = '0; alu = '0; wdata = '0; wreg = '0;
        {z_v, z_rd, z_wr, z_m2r, z_rw} = '0; z_alu = '0; z_wdata = '0; z_wreg = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset valid", 32'(o_valid), 32'd0);
        chk("reset regwrite", 32'(o_rw), 32'd0);
        chk("reset memtoreg", 32'(o_m2r), 32'd0);
        chk("reset read_data", o_rd, 32'd0);
        chk("reset alu_result", o_alu, 32'd0);
        chk("reset write_reg", 32'(o_wreg), 32'd0);
        chk("reset mem_stall", 32'(stall), 32'd0);
        chk("reset ws0 valid", 32'(z_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i], i);

        // Reset lands in the second wait cycle of a store: the write must be dropped.
        @(negedge clk);
        v = 1; rd = 0; wr = 1; m2r = 0; rw = 0; alu = 32'h20; wdata = 32'h1234; wreg = 5'd0;
        #1 chk("abort stall presented", 32'(stall), 32'd1);
        @(posedge clk); @(negedge clk); #1;
        chk("abort stall wait1", 32'(stall), 32'd1);
        @(posedge clk); @(negedge clk); #1;
        chk("abort stall wait2", 32'(stall), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort valid", 32'(o_valid), 32'd0);
        chk("abort regwrite", 32'(o_rw), 32'd0);
        chk("abort memtoreg", 32'(o_m2r), 32'd0);
        chk("abort alu_result", o_alu, 32'd0);
        chk("abort write_reg", 32'(o_wreg), 32'd0);
        chk("abort read_data", o_rd, 32'd0);
        @(negedge clk);
        rst = 1'b0; v = 0; wr = 0;
        #1 chk("after reset mem_stall", 32'(stall), 32'd0);
        last_alu = '0; last_wreg = '0; last_rd = '0;
        run_vec(mk(1, 1, 0, 1, 1, 32'h20, 32'h0, 5'd13, 32'h0, 1, 2), 12);

        // Zero wait states: stores then back-to-back loads, one result per edge.
        @(negedge clk);
        z_v = 1; z_wr = 1; z_rd = 0; z_alu = 32'h0; z_wdata = 32'hCAFEF00D;
        #1 chk("ws0 stall store0", 32'(z_stall), 32'd0);
        @(negedge clk);
        z_alu = 32'h4; z_wdata = 32'h0BADF00D;
        #1 chk("ws0 stall store4", 32'(z_stall), 32'd0);
        @(negedge clk);
        z_wr = 0; z_rd = 1; z_m2r = 1; z_rw = 1; z_alu = 32'h0; z_wreg = 5'd1;
        #1 chk("ws0 stall load0", 32'(z_stall), 32'd0);
        @(posedge clk); #1;
        chk("ws0 load0 data", z_ord, 32'hCAFEF00D);
        chk("ws0 load0 valid", 32'(z_valid), 32'd1);
        @(negedge clk);
        z_alu = 32'h4; z_wreg = 5'd2;
        #1 chk("ws0 stall load4", 32'(z_stall), 32'd0);
        @(posedge clk); #1;
        chk("ws0 load4 data", z_ord, 32'h0BADF00D);
        chk("ws0 load4 valid", 32'(z_valid), 32'd1);
        chk("ws0 load4 write_reg", 32'(z_owreg), 32'd2);
        @(negedge clk);
        z_v = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the data memory word-address width (2**ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_STATES, default 2, giving extra stall cycles per load/store (legal 0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port EX_MEM_valid, input, 1, meaning the EX/MEM latch holds a live instruction.
REQ-006 SHALL have port EX_MEM_memread, input, 1, meaning load.
REQ-007 SHALL have port EX_MEM_memwrite, input, 1, meaning store.
REQ-008 SHALL have ports EX_MEM_memtoreg and EX_MEM_regwrite, input, 1 each, as WB controls passed through.
REQ-009 SHALL have port EX_MEM_alu_result, input, 32, the byte address or the ALU result.
REQ-010 SHALL have port EX_MEM_write_data, input, 32, the store data.
REQ-011 SHALL have port EX_MEM_write_reg, input, 5, the destination register.
REQ-012 SHALL have ports MEM_WB_valid, MEM_WB_memtoreg and MEM_WB_regwrite, output, 1 each, all registered.
REQ-013 SHALL have ports read_data and mem_alu_result, output, 32 each, registered and feeding the writeback mux.
REQ-014 SHALL have port MEM_WB_write_reg, output, 5, registered.
REQ-015 SHALL have port mem_stall, output, 1, combinational; while high, upstream holds the EX/MEM inputs stable.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-017 In IDLE, an access (EX_MEM_valid and (memread or memwrite)) with WAIT_STATES>0 SHALL load a counter with WAIT_STATES, move to WAIT, and assert mem_stall.
REQ-018 In WAIT, the counter SHALL decrement each cycle; mem_stall SHALL be high while counter != 1; at counter==1, mem_stall SHALL be low and the FSM SHALL return to IDLE at the next edge.
REQ-019 An access SHALL complete on the edge where mem_stall is low; total latency is WAIT_STATES+1 cycles from first presentation to the MEM/WB update.
REQ-020 On a completing edge, MEM/WB SHALL capture valid=1, the control bits, alu_result, write_reg, and read_data = mem[alu_result[ADDR_W+1:2]] for a load (0 otherwise).
REQ-021 A store SHALL write EX_MEM_write_data to mem[alu_result[ADDR_W+1:2]] only on its completing edge; address bits above ADDR_W+1 SHALL be ignored.
REQ-022 A non-memory valid instruction SHALL complete in 1 cycle with no stall.
REQ-023 On every edge where mem_stall is high, or where EX_MEM_valid is 0, MEM/WB SHALL capture a bubble: valid=0, regwrite=0, memtoreg=0; data fields SHALL hold their previous values.
REQ-024 If memread and memwrite are both high, the instruction SHALL be treated as a store, and read_data SHALL be 0.
REQ-025 A load immediately following a store to the same address SHALL return the newly stored value.

Reset
REQ-026 With rst high at an edge, the FSM SHALL go to IDLE, the counter SHALL clear, and all MEM/WB outputs SHALL become 0; mem_stall SHALL be 0 in the following cycle.
REQ-027 Reset during WAIT SHALL abort the access; a pending store SHALL NOT be written.
REQ-028 Data memory contents SHALL NOT be altered by rst; they SHALL be zero at time zero.

Configuration
REQ-029 With macro MEM_MISALIGN_CHK_EN defined, an access with alu_result[1:0] != 0 SHALL complete in 1 cycle with no stall, SHALL suppress the store, SHALL return read_data 0, and SHALL force MEM_WB_regwrite to 0.
REQ-030 Without MEM_MISALIGN_CHK_EN, alu_result[1:0] SHALL be ignored and the access SHALL proceed word-aligned.

Verification
REQ-031 WAIT_STATES=2: store 0xDEADBEEF to address 0x10, then load 0x10 -> mem_stall high for 2 cycles per access; the load yields read_data=0xDEADBEEF, MEM_WB_valid=1, 3 cycles after the load is presented.
REQ-032 Non-memory add, alu_result=0x5, write_reg=7 -> next edge gives mem_alu_result=0x5, MEM_WB_write_reg=7, MEM_WB_regwrite=1, no stall.
REQ-033 Assert rst in the second WAIT cycle of a store of 0x1234 to 0x20 -> outputs 0, FSM IDLE; a later load of 0x20 returns 0.
REQ-034 Stall cycles -> MEM_WB_valid=0 and MEM_WB_regwrite=0 on every stalled edge.
REQ-035 With MEM_MISALIGN_CHK_EN, store to 0x13 -> no stall, memory unchanged, MEM_WB_regwrite=0; without it -> word 0x10 written.
REQ-036 WAIT_STATES=0: back-to-back loads to 0x0 and 0x4 -> results on consecutive edges, mem_stall never high.
